fetch_unit_mips: RTL and testbench

Instruction fetch stage of the MIPS processor. Owns the program counter and issues word reads to a synchronous instruction memory. Buffers returned words in a 2-entry queue and presents them, with their PC, to the decode stage (main and ALU control units) over a valid/ready handshake. Branch and jump redirects come from the data tract; the block flushes stale fetches and restarts at the new target.

---
 rtl/mips_pkg.sv | 13 +
 rtl/fetch_buffer_mips.sv | 59 +++++
 rtl/fetch_unit_mips.sv | 143 ++++++++++++++
 tb/tb_fetch_unit_mips.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS fetch-path definitions: default reset PC, instruction width and
// the fetch queue entry that pairs an instruction word with its address.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_W          = 32;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mips.sv
// Two-entry FIFO of fetched instructions with synchronous flush. A flush may
// optionally retain the entry behind the head (used to keep a delay slot).
module fetch_buffer_mips
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         keep_next,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count_q;

  // A flush with push leaves exactly the pushed entry; keep_next slides the
  // second entry into the head position and frees the old head slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      if (keep_next && count_q == 2'd2) begin
        rd_ptr  <= ~rd_ptr;
        wr_ptr  <= rd_ptr;
        count_q <= 2'd1;
      end else if (push) begin
        mem[0]  <= push_data;
        rd_ptr  <= 1'b0;
        wr_ptr  <= 1'b1;
        count_q <= 2'd1;
      end else begin
        rd_ptr  <= 1'b0;
        wr_ptr  <= 1'b0;
        count_q <= 2'd0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit_mips.sv
// MIPS fetch stage: PC, credit-limited imem requests, 2-entry return queue,
// redirect flush and sticky misaligned-target fault. Option: FETCH_MIPS_DELAY_SLOT_EN.
module fetch_unit_mips
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic               o_imem_req,
  output logic [IMEM_AW-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic [31:0]        i_imem_rdata,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_pc_plus4,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_fault
);

  logic [31:0]  pc_q;
  logic [31:0]  pc_next;
  logic         fault_q;
  logic         inflight_q;
  logic         inflight_drop_q;
  logic [31:0]  inflight_pc_q;
  logic         drop_next;
  logic         keep_next;
  logic         push;
  fetch_entry_t push_data;
  fetch_entry_t head;
  logic [1:0]   count;
  logic [2:0]   load;
  logic         pop;
  logic         grant;
  logic         arrive;
  logic         misaligned;

  fetch_buffer_mips u_buffer (
    .clk       (i_clk),
    .reset     (i_reset),
    .flush     (i_redirect),
    .keep_next (keep_next),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign o_valid    = (count != 2'd0) && !fault_q;
  assign o_instr    = head.instr;
  assign o_pc       = head.pc;
  assign o_pc_plus4 = head.pc + 32'd4;
  assign o_fault    = fault_q;
  assign pop        = o_valid && i_ready;

  // Queued plus in-flight words, minus the one leaving now, must leave a slot.
  assign load        = {1'b0, count} + {2'b00, inflight_q};
  assign o_imem_req  = !i_reset && !fault_q && (load < (3'd2 + {2'b00, pop}));
  assign o_imem_addr = pc_q[IMEM_AW+1:2];
  assign grant       = o_imem_req && i_imem_gnt;
  assign arrive      = inflight_q && !inflight_drop_q;
  assign misaligned  = i_redirect && (i_redirect_pc[1:0] != 2'b00);

`ifdef FETCH_MIPS_DELAY_SLOT_EN
  logic        pend_q;
  logic        pend_next;
  logic [31:0] pend_pc_q;
  logic [31:0] pend_pc_next;
  logic        ds;

  assign ds = i_redirect && pop && !misaligned;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_next;
      pend_pc_q <= pend_pc_next;
    end
  end
`endif

  always_comb begin
    keep_next       = 1'b0;
    push            = arrive && !i_redirect;
    push_data.pc    = inflight_pc_q;
    push_data.instr = i_imem_rdata;
    drop_next       = i_redirect;
    pc_next         = pc_q;
    if (grant) pc_next = pc_q + 32'd4;
`ifdef FETCH_MIPS_DELAY_SLOT_EN
    pend_next    = pend_q;
    pend_pc_next = pend_pc_q;
    if (grant && pend_q) begin
      pc_next   = pend_pc_q;
      pend_next = 1'b0;
    end
    if (i_redirect) pend_next = 1'b0;
`endif
    if (i_redirect) pc_next = i_redirect_pc;
`ifdef FETCH_MIPS_DELAY_SLOT_EN
    // The slot (popped PC + 4) survives from the queue, the arriving word or
    // this cycle's grant; failing all three it is fetched before the target.
    if (ds) begin
      if (count == 2'd2) begin
        keep_next = 1'b1;
      end else if (arrive && inflight_pc_q == o_pc_plus4) begin
        push = 1'b1;
      end else if (grant && pc_q == o_pc_plus4) begin
        drop_next = 1'b0;
      end else begin
        pc_next      = o_pc_plus4;
        pend_next    = 1'b1;
        pend_pc_next = i_redirect_pc;
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q            <= RESET_PC;
      fault_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_drop_q <= 1'b0;
      inflight_pc_q   <= '0;
    end else begin
      pc_q            <= pc_next;
      inflight_q      <= grant;
      inflight_drop_q <= drop_next;
      inflight_pc_q   <= pc_q;
      if (misaligned) fault_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit_mips.sv
// Table-driven bench for fetch_unit_mips: stream, backpressure, grant stall,
// redirect and misaligned fault; expectations follow FETCH_MIPS_DELAY_SLOT_EN.
module tb_fetch_unit_mips;

  logic        i_clk;
  logic        i_reset;
  logic        o_imem_req;
  logic [9:0]  o_imem_addr;
  logic        i_imem_gnt;
  logic [31:0] i_imem_rdata;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_fault;

  int checks;
  int failures;

  typedef struct {
    int          seq;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        gnt;
    logic        ready;
    logic        exp_req;
    logic [9:0]  exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[$];

  fetch_unit_mips dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (i_imem_gnt),
    .i_imem_rdata  (i_imem_rdata),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .o_pc_plus4    (o_pc_plus4),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_fault       (o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory word k holds 32'h1000_0000 + k, returned the cycle after a grant.
  always @(posedge i_clk) begin
    if (o_imem_req && i_imem_gnt) i_imem_rdata <= 32'h1000_0000 + {22'b0, o_imem_addr};
    else                          i_imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic addVec(input int seq, input logic redirect, input logic [31:0] rpc,
                        input logic gnt, input logic ready, input logic req,
                        input logic [9:0] addr, input logic valid,
                        input logic [31:0] pc, input logic fault);
    vec_t v;
    v.seq = seq; v.redirect = redirect; v.redirect_pc = rpc;
    v.gnt = gnt; v.ready = ready; v.exp_req = req; v.exp_addr = addr;
    v.exp_valid = valid; v.exp_pc = pc; v.exp_fault = fault;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_redirect    = v.redirect;
    i_redirect_pc = v.redirect_pc;
    i_imem_gnt    = v.gnt;
    i_ready       = v.ready;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkValue("req", idx, {31'b0, o_imem_req}, {31'b0, v.exp_req});
    if (v.exp_req) checkValue("addr", idx, {22'b0, o_imem_addr}, {22'b0, v.exp_addr});
    checkValue("valid", idx, {31'b0, o_valid}, {31'b0, v.exp_valid});
    if (v.exp_valid) begin
      checkValue("pc", idx, o_pc, v.exp_pc);
      checkValue("instr", idx, o_instr, 32'h1000_0000 + (v.exp_pc >> 2));
      checkValue("pc_plus4", idx, o_pc_plus4, v.exp_pc + 32'd4);
    end
    checkValue("fault", idx, {31'b0, o_fault}, {31'b0, v.exp_fault});
  endtask

  task automatic doReset();
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_gnt    = 1'b0;
    i_ready       = 1'b0;
    step();
    step();
    #3;
    checkValue("rst_req", -1, {31'b0, o_imem_req}, 32'd0);
    checkValue("rst_valid", -1, {31'b0, o_valid}, 32'd0);
    checkValue("rst_instr", -1, o_instr, 32'd0);
    checkValue("rst_pc", -1, o_pc, 32'd0);
    checkValue("rst_pc_plus4", -1, o_pc_plus4, 32'd4);
    checkValue("rst_fault", -1, {31'b0, o_fault}, 32'd0);
  endtask

  task automatic addStream(input int seq, input int n);
    for (int k = 0; k < n; k++)
      addVec(seq, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 10'(k), k >= 2,
             (k >= 2) ? 32'(4 * (k - 2)) : 32'h0, 1'b0);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    i_reset       = 1'b1;
    i_redirect    = 1'b0;
    i_redirect_pc = 32'h0;
    i_imem_gnt    = 1'b0;
    i_ready       = 1'b0;

    // seq 0: continuous grant and ready, one instruction per cycle
    addStream(0, 10);

    // seq 1: ready low for 5 cycles after the first valid
    addVec(1, 0, 0, 1, 1, 1, 10'd0, 0, 32'h0, 0);
    addVec(1, 0, 0, 1, 1, 1, 10'd1, 0, 32'h0, 0);
    for (int k = 2; k <= 6; k++) addVec(1, 0, 0, 1, 0, 0, 10'd0, 1, 32'h0, 0);
    addVec(1, 0, 0, 1, 1, 1, 10'd2, 1, 32'h0, 0);
    addVec(1, 0, 0, 1, 1, 1, 10'd3, 1, 32'h4, 0);
    addVec(1, 0, 0, 1, 1, 1, 10'd4, 1, 32'h8, 0);
    addVec(1, 0, 0, 1, 1, 1, 10'd5, 1, 32'hC, 0);

    // seq 2: grant withheld for 3 cycles, address must hold
    addVec(2, 0, 0, 1, 1, 1, 10'd0, 0, 32'h0, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd1, 0, 32'h0, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd2, 1, 32'h0, 0);
    addVec(2, 0, 0, 0, 1, 1, 10'd3, 1, 32'h4, 0);
    addVec(2, 0, 0, 0, 1, 1, 10'd3, 1, 32'h8, 0);
    addVec(2, 0, 0, 0, 1, 1, 10'd3, 0, 32'h0, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd3, 0, 32'h0, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd4, 0, 32'h0, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd5, 1, 32'hC, 0);
    addVec(2, 0, 0, 1, 1, 1, 10'd6, 1, 32'h10, 0);

    // seq 3: redirect to 0x40 while PC 8 is popped
    addStream(3, 4);
    addVec(3, 1, 32'h40, 1, 1, 1, 10'd4, 1, 32'h8, 0);
`ifdef FETCH_MIPS_DELAY_SLOT_EN
    addVec(3, 0, 32'h0, 1, 1, 1, 10'd16, 1, 32'hC, 0);
`else
    addVec(3, 0, 32'h0, 1, 1, 1, 10'd16, 0, 32'h0, 0);
`endif
    addVec(3, 0, 32'h0, 1, 1, 1, 10'd17, 0, 32'h0, 0);
    addVec(3, 0, 32'h0, 1, 1, 1, 10'd18, 1, 32'h40, 0);
    addVec(3, 0, 32'h0, 1, 1, 1, 10'd19, 1, 32'h44, 0);

    // seq 4: misaligned redirect target locks the stage until reset
    addStream(4, 4);
    addVec(4, 1, 32'h42, 1, 1, 1, 10'd4, 1, 32'h8, 0);
    for (int k = 5; k <= 8; k++) addVec(4, 0, 32'h0, 1, 1, 0, 10'd0, 0, 32'h0, 1);

    // seq 5: after reset the stream restarts at the reset PC
    addStream(5, 5);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 0 || vecs[i].seq != vecs[i-1].seq) doReset();
      step();
      i_reset = 1'b0;
      applyStimulus(vecs[i]);
      #3;
      checkOutput(i, vecs[i]);
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
